// File: rtl/rc4_pkg.sv
// Shared RC4 definitions used by the KSA stage, the PRGA/decrypt stage and
// the key-search master.
//   state_t         : PRGA/decrypt state encoding
//   CHAR_LO/HI      : inclusive range of legal lowercase plaintext characters
//   CHAR_SPACE      : the only other legal plaintext character
//   DEFAULT_MSG_LEN : message length in bytes
//   addr_width()    : message address width; kept at least 1 bit so that a
//                     one-byte message still has a usable port
package rc4_pkg;

    localparam int DEFAULT_MSG_LEN = 32;

    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_INC_I,
        ST_RD_SI,
        ST_CAP_SI,
        ST_RD_SJ,
        ST_CAP_SJ,
        ST_WR_SI,
        ST_WR_SJ,
        ST_RD_F,
        ST_CAP_F,
        ST_WR_OUT,
        ST_DONE
    } state_t;

    function automatic int addr_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/rc4_decrypt_prga_if.sv
// Bus bundle between the PRGA/decrypt stage and its surroundings.
//   start/finish/valid : run handshake with the key-search master
//   s_*                : S RAM port (one-cycle registered read)
//   rom_*              : encrypted-message ROM (one-cycle registered read)
//   ram_*              : decrypted-message RAM write port
// Modports: slave = the decrypt stage, master = master plus memories.
interface rc4_decrypt_prga_if
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = DEFAULT_MSG_LEN
);
    localparam int AW = addr_width(MSG_LEN);

    logic          start;
    logic          finish;
    logic          valid;
    logic [7:0]    s_address;
    logic [7:0]    s_data_in;
    logic [7:0]    s_data_out;
    logic          s_write_enable;
    logic [AW-1:0] rom_address;
    logic [7:0]    rom_data;
    logic [AW-1:0] ram_address;
    logic [7:0]    ram_data_out;
    logic          ram_write_enable;

    modport slave (
        input  start, s_data_in, rom_data,
        output finish, valid, s_address, s_data_out, s_write_enable,
               rom_address, ram_address, ram_data_out, ram_write_enable
    );

    modport master (
        output start, s_data_in, rom_data,
        input  finish, valid, s_address, s_data_out, s_write_enable,
               rom_address, ram_address, ram_data_out, ram_write_enable
    );

endinterface

// File: rtl/rc4_char_check.sv
// Combinational plaintext character filter.
//   char_in : candidate plaintext byte
//   legal   : 1 when char_in is 'a'..'z' or space
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] char_in,
    output logic       legal
);

    assign legal = ((char_in >= CHAR_LO) && (char_in <= CHAR_HI)) ||
                   (char_in == CHAR_SPACE);

endmodule

// File: rtl/rc4_decrypt_prga.sv
// RC4 PRGA + decrypt stage. Walks the pre-scheduled S memory, XORs each
// keystream byte with the encrypted ROM byte, writes the plaintext to the
// decrypted RAM and stops early on the first illegal character.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : start/finish/valid handshake, S RAM, ROM and RAM ports
// Every byte takes ten states; all strobes and addresses are decoded from
// the registered state so they are glitch-free.
module rc4_decrypt_prga
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = DEFAULT_MSG_LEN
) (
    input  logic              clock,
    input  logic              reset,
    rc4_decrypt_prga_if.slave bus
);

    localparam int AW = addr_width(MSG_LEN);
    localparam logic [AW-1:0] LAST_K = AW'(MSG_LEN - 1);

    state_t        state_reg, state_next;
    logic [7:0]    i_reg, j_reg, si_reg, sj_reg, f_reg, enc_reg;
    logic [AW-1:0] k_reg;
    logic          valid_reg;

    logic [7:0]    plain_byte;
    logic          plain_legal;
    logic          last_byte;

    logic [7:0]    s_addr_comb, s_wdata_comb, ram_wdata_comb;
    logic          s_we_comb, ram_we_comb, finish_comb;

    assign plain_byte = f_reg ^ enc_reg;
    assign last_byte  = (k_reg == LAST_K);

    rc4_char_check u_char_check (
        .char_in (plain_byte),
        .legal   (plain_legal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            si_reg    <= '0;
            sj_reg    <= '0;
            f_reg     <= '0;
            enc_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_INIT: begin
                    i_reg     <= '0;
                    j_reg     <= '0;
                    k_reg     <= '0;
                    valid_reg <= 1'b1;
                end
                ST_INC_I:  i_reg <= i_reg + 8'd1;
                ST_CAP_SI: begin
                    si_reg <= bus.s_data_in;
                    j_reg  <= j_reg + bus.s_data_in;
                end
                ST_CAP_SJ: sj_reg <= bus.s_data_in;
                ST_CAP_F: begin
                    f_reg   <= bus.s_data_in;
                    enc_reg <= bus.rom_data;
                end
                ST_WR_OUT: begin
                    valid_reg <= valid_reg & plain_legal;
                    // k stays on the last written byte when the run ends
                    if (!last_byte && plain_legal)
                        k_reg <= k_reg + AW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next     = state_reg;
        s_addr_comb    = 8'd0;
        s_wdata_comb   = 8'd0;
        s_we_comb      = 1'b0;
        ram_wdata_comb = 8'd0;
        ram_we_comb    = 1'b0;
        finish_comb    = 1'b0;
        case (state_reg)
            ST_IDLE:   if (bus.start) state_next = ST_INIT;
            ST_INIT:   state_next = ST_INC_I;
            ST_INC_I:  state_next = ST_RD_SI;
            // Read states hold the address for two cycles: present, then capture.
            ST_RD_SI: begin
                s_addr_comb = i_reg;
                state_next  = ST_CAP_SI;
            end
            ST_CAP_SI: begin
                s_addr_comb = i_reg;
                state_next  = ST_RD_SJ;
            end
            ST_RD_SJ: begin
                s_addr_comb = j_reg;
                state_next  = ST_CAP_SJ;
            end
            ST_CAP_SJ: begin
                s_addr_comb = j_reg;
                state_next  = ST_WR_SI;
            end
            // When i == j both writes store the same value, which is correct.
            ST_WR_SI: begin
                s_addr_comb  = i_reg;
                s_wdata_comb = sj_reg;
                s_we_comb    = 1'b1;
                state_next   = ST_WR_SJ;
            end
            ST_WR_SJ: begin
                s_addr_comb  = j_reg;
                s_wdata_comb = si_reg;
                s_we_comb    = 1'b1;
                state_next   = ST_RD_F;
            end
            // Post-swap S[i]+S[j] equals sj+si; 8-bit sum wraps mod 256.
            ST_RD_F: begin
                s_addr_comb = si_reg + sj_reg;
                state_next  = ST_CAP_F;
            end
            ST_CAP_F: begin
                s_addr_comb = si_reg + sj_reg;
                state_next  = ST_WR_OUT;
            end
            ST_WR_OUT: begin
                ram_we_comb    = 1'b1;
                ram_wdata_comb = plain_byte;
                state_next     = (last_byte || !plain_legal) ? ST_DONE : ST_INC_I;
            end
            ST_DONE: begin
                finish_comb = 1'b1;
                state_next  = ST_IDLE;
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    assign bus.finish           = finish_comb;
    assign bus.valid            = valid_reg;
    assign bus.s_address        = s_addr_comb;
    assign bus.s_data_out       = s_wdata_comb;
    assign bus.s_write_enable   = s_we_comb;
    assign bus.rom_address      = k_reg;
    assign bus.ram_address      = k_reg;
    assign bus.ram_data_out     = ram_wdata_comb;
    assign bus.ram_write_enable = ram_we_comb;

endmodule

// File: tb/tb_rc4_decrypt_prga.sv
module tb_rc4_decrypt_prga;
    import rc4_pkg::*;

    localparam int MSG_LEN   = 32;
    localparam int RUN_LIMIT = 2 + 10 * MSG_LEN + 60;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rc4_decrypt_prga_if #(.MSG_LEN(MSG_LEN)) bus ();

    rc4_decrypt_prga #(.MSG_LEN(MSG_LEN)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- memories around the DUT (registered reads) ----------
    logic [7:0]  s_mem   [256];
    logic [7:0]  rom_mem [MSG_LEN];
    logic [7:0]  ram_mem [MSG_LEN];
    logic [7:0]  s_init  [256];
    logic [7:0]  enc_init[MSG_LEN];
    logic        mem_load = 1'b0;
    int          ram_wr_count = 0;
    logic [15:0] s_wr_log[$];

    always @(posedge clock) begin
        if (mem_load) begin
            for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
            for (int x = 0; x < MSG_LEN; x++) begin
                rom_mem[x] <= enc_init[x];
                ram_mem[x] <= 8'h00;
            end
            ram_wr_count <= 0;
            s_wr_log.delete();
        end else begin
            bus.s_data_in <= s_mem[bus.s_address];
            bus.rom_data  <= rom_mem[bus.rom_address];
            if (bus.s_write_enable) begin
                s_mem[bus.s_address] <= bus.s_data_out;
                s_wr_log.push_back({bus.s_address, bus.s_data_out});
            end
            if (bus.ram_write_enable) begin
                ram_mem[bus.ram_address] <= bus.ram_data_out;
                ram_wr_count <= ram_wr_count + 1;
            end
        end
    end

    // ---------------- reference model (plain RC4 over arrays) --------------
    logic [7:0] m_s[256];
    logic [7:0] m_ks[MSG_LEN];
    logic [7:0] exp_ram[MSG_LEN];
    int         exp_writes;
    bit         exp_valid;

    function automatic bit is_legal(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    function automatic logic [7:0] rand_legal();
        int r = $urandom_range(0, 26);
        return (r == 26) ? 8'h20 : 8'(8'h61 + r);
    endfunction

    function automatic logic [7:0] rand_illegal();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (is_legal(b));
        return b;
    endfunction

    // Full keystream from s_init, ignoring any early stop.
    task automatic model_keystream();
        logic [7:0] ii, jj, t, fa;
        m_s = s_init; ii = 0; jj = 0;
        for (int k = 0; k < MSG_LEN; k++) begin
            ii = ii + 8'd1;
            jj = jj + m_s[ii];
            t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
            fa = m_s[ii] + m_s[jj];
            m_ks[k] = m_s[fa];
        end
    endtask

    // Expected decrypt of enc_init from s_init, stopping after the first illegal byte.
    task automatic model_run();
        logic [7:0] ii, jj, t, fa, p;
        m_s = s_init; ii = 0; jj = 0; exp_writes = 0; exp_valid = 1'b1;
        for (int k = 0; k < MSG_LEN; k++) begin
            ii = ii + 8'd1;
            jj = jj + m_s[ii];
            t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
            fa = m_s[ii] + m_s[jj];
            p = m_s[fa] ^ enc_init[k];
            exp_ram[k] = p;
            exp_writes = k + 1;
            if (!is_legal(p)) begin
                exp_valid = 1'b0;
                break;
            end
        end
    endtask

    // Plaintext of legal characters, optionally one illegal byte at bad_pos.
    task automatic make_enc(input int bad_pos);
        model_keystream();
        for (int k = 0; k < MSG_LEN; k++)
            enc_init[k] = m_ks[k] ^ ((k == bad_pos) ? rand_illegal() : rand_legal());
    endtask

    task automatic identity_s();
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    endtask

    task automatic random_perm_s();
        logic [7:0] t;
        int r;
        identity_s();
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(0, x);
            t = s_init[x]; s_init[x] = s_init[r]; s_init[r] = t;
        end
    endtask

    // ---------------- checking helpers ------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic load_mems();
        @(negedge clock); mem_load = 1'b1;
        @(negedge clock); mem_load = 1'b0;
    endtask

    task automatic run_and_wait(output int fin_cycle, output bit fin_valid);
        int cyc;
        @(negedge clock); bus.start = 1'b1;
        @(posedge clock);
        cyc = 0; fin_cycle = -1; fin_valid = 1'b0;
        while (cyc < RUN_LIMIT) begin
            @(negedge clock); cyc++;
            if (cyc == 1) bus.start = 1'b0;
            if (bus.finish) begin
                fin_cycle = cyc;
                fin_valid = bus.valid;
                break;
            end
        end
    endtask

    task automatic check_run(input string name, input int fin_cycle, input bit fin_valid);
        int bad = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) bad++;
        $display("run %s: writes=%0d finish_cycle=%0d valid=%0b", name, ram_wr_count, fin_cycle, fin_valid);
        check({name, ".finish_cycle"}, 32'(fin_cycle), 32'(2 + 10 * exp_writes));
        check({name, ".valid"}, 32'(fin_valid), 32'(exp_valid));
        check({name, ".writes"}, 32'(ram_wr_count), 32'(exp_writes));
        for (int k = 0; k < exp_writes; k++)
            check($sformatf("%s.ram[%0d]", name, k), 32'(ram_mem[k]), 32'(exp_ram[k]));
        check({name, ".final_s_mismatches"}, 32'(bad), 32'd0);
    endtask

    // ---------------- directed table ------------------------------------
    typedef struct {
        logic [7:0] enc0;
        logic [7:0] exp_ram0;
        int         exp_writes;
        int         exp_finish;
        bit         exp_valid;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] outputs_or();
        return {23'd0, bus.finish, bus.valid, bus.s_write_enable, bus.ram_write_enable,
                |bus.s_address, |bus.s_data_out, |bus.rom_address, |bus.ram_address,
                |bus.ram_data_out};
    endfunction

    initial begin
        int fc, cyc, snap_wr, snap_log;
        bit fv;
        logic [7:0] key[3];

        // Identity S: keystream byte 0 is 8'h02, byte 1 is 8'h05.
        vecs[0] = '{8'h63, 8'h61, 32, 322, 1'b1};
        vecs[1] = '{8'h02, 8'h00,  1,  12, 1'b0};
        vecs[2] = '{8'h22, 8'h20, 32, 322, 1'b1};
        vecs[3] = '{8'h78, 8'h7A, 32, 322, 1'b1};
        vecs[4] = '{8'h62, 8'h60,  1,  12, 1'b0};
        vecs[5] = '{8'h79, 8'h7B,  1,  12, 1'b0};
        vecs[6] = '{8'h23, 8'h21,  1,  12, 1'b0};
        vecs[7] = '{8'h1D, 8'h1F,  1,  12, 1'b0};

        reset = 1'b1; bus.start = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs_during_reset", outputs_or(), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("reset_outputs_after_release", outputs_or(), 32'd0);

        // Table-driven byte-0 cases on identity S.
        for (int v = 0; v < 8; v++) begin
            identity_s();
            make_enc(-1);
            enc_init[0] = vecs[v].enc0;
            enc_init[1] = 8'h67;
            model_run();
            load_mems();
            run_and_wait(fc, fv);
            check($sformatf("vec%0d.ram0", v), 32'(ram_mem[0]), 32'(vecs[v].exp_ram0));
            check($sformatf("vec%0d.writes", v), 32'(ram_wr_count), 32'(vecs[v].exp_writes));
            check($sformatf("vec%0d.finish_cycle", v), 32'(fc), 32'(vecs[v].exp_finish));
            check($sformatf("vec%0d.valid", v), 32'(fv), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_writes == 32) begin
                check($sformatf("vec%0d.ram1", v), 32'(ram_mem[1]), 32'h62);
                check($sformatf("vec%0d.swap1_si", v), (s_wr_log.size() > 2) ? 32'(s_wr_log[2]) : 32'hDEAD, 32'h0203);
                check($sformatf("vec%0d.swap1_sj", v), (s_wr_log.size() > 3) ? 32'(s_wr_log[3]) : 32'hDEAD, 32'h0302);
            end
            check_run($sformatf("vec%0d", v), fc, fv);
        end

        // KSA-scheduled S for key 24'h000249.
        begin
            logic [7:0] jj, t;
            key[0] = 8'h00; key[1] = 8'h02; key[2] = 8'h49;
            identity_s(); jj = 0;
            for (int x = 0; x < 256; x++) begin
                jj = jj + s_init[x] + key[x % 3];
                t = s_init[x]; s_init[x] = s_init[jj]; s_init[jj] = t;
            end
        end
        make_enc(-1);
        model_run();
        load_mems();
        run_and_wait(fc, fv);
        check_run("ksa_key_000249", fc, fv);

        // Modulo-256 wrap of j and of the f address.
        identity_s();
        s_init[8'h01] = 8'hF0; s_init[8'hF0] = 8'h01;
        s_init[8'h02] = 8'h20; s_init[8'h20] = 8'h02;
        make_enc(-1);
        enc_init[0] = 8'h90;   // f0 = S[F1] = F1
        enc_init[1] = 8'h51;   // f1 = S[30] = 30
        model_run();
        load_mems();
        run_and_wait(fc, fv);
        check("wrap.ram0", 32'(ram_mem[0]), 32'h61);
        check("wrap.ram1", 32'(ram_mem[1]), 32'h61);
        check("wrap.byte0_sj_write", (s_wr_log.size() > 1) ? 32'(s_wr_log[1]) : 32'hDEAD, 32'hF0F0);
        check("wrap.byte1_si_write", (s_wr_log.size() > 2) ? 32'(s_wr_log[2]) : 32'hDEAD, 32'h0210);
        check("wrap.byte1_sj_write", (s_wr_log.size() > 3) ? 32'(s_wr_log[3]) : 32'hDEAD, 32'h1020);
        check_run("wrap", fc, fv);

        // Reset in cycle 50, then reload and rerun.
        random_perm_s();
        make_enc(-1);
        model_run();
        load_mems();
        @(negedge clock); bus.start = 1'b1;
        @(posedge clock);
        for (cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clock);
            if (cyc == 1) bus.start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midrun_reset_outputs", outputs_or(), 32'd0);
        reset = 1'b0;
        snap_wr = ram_wr_count; snap_log = s_wr_log.size();
        repeat (30) @(negedge clock);
        check("midrun_reset_no_ram_writes", 32'(ram_wr_count), 32'(snap_wr));
        check("midrun_reset_no_s_writes", 32'(s_wr_log.size()), 32'(snap_log));
        load_mems();
        run_and_wait(fc, fv);
        check_run("after_reset", fc, fv);

        // Start pulse mid-run ignored; start held through DONE restarts.
        random_perm_s();
        make_enc(-1);
        model_run();
        load_mems();
        @(negedge clock); bus.start = 1'b1;
        @(posedge clock);
        cyc = 0; fc = -1;
        while (cyc < RUN_LIMIT) begin
            @(negedge clock); cyc++;
            if (cyc == 1)   bus.start = 1'b0;
            if (cyc == 100) bus.start = 1'b1;
            if (cyc == 101) bus.start = 1'b0;
            if (cyc == 200) bus.start = 1'b1;
            if (bus.finish) begin fc = cyc; fv = bus.valid; break; end
        end
        check_run("start_pulse_run1", fc, fv);
        s_init = m_s;           // second run starts from the un-restored S
        model_run();
        fc = -1;
        while (cyc < 2 * RUN_LIMIT) begin
            @(negedge clock); cyc++;
            if (cyc == 324) bus.start = 1'b0;
            if (bus.finish) begin fc = cyc; fv = bus.valid; break; end
        end
        bus.start = 1'b0;
        $display("run start_hold_run2: finish_cycle=%0d valid=%0b", fc, fv);
        check("restart.finish_cycle", 32'(fc), 32'(323 + 2 + 10 * exp_writes));
        check("restart.valid", 32'(fv), 32'(exp_valid));
        check("restart.total_writes", 32'(ram_wr_count), 32'(MSG_LEN + exp_writes));

        // Randomized runs, some with an injected illegal byte.
        for (int r = 0; r < 6; r++) begin
            random_perm_s();
            make_enc(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, MSG_LEN - 1)) : -1);
            model_run();
            load_mems();
            run_and_wait(fc, fv);
            check_run($sformatf("random%0d", r), fc, fv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_decrypt_prga.md
# rc4_decrypt_prga

RC4 pseudo-random generation and decryption stage, placed directly downstream of the key-scheduling (swap) stage. After the master pulses `start`, it walks the already-scheduled S memory with the RC4 PRGA and XORs each keystream byte with one byte from the encrypted-message ROM. It writes each plaintext byte to the decrypted-message RAM and reports whether every byte is a legal character, so the key-search master can reject a key early.

## Interface
- `MSG_LEN`, 32: message length in bytes (ROM/RAM depth); legal range 1–256.
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE.
- `finish`  out  1  one-cycle pulse at end of run.
- `valid`  out  1  qualified by `finish`; 1 = all written bytes legal.
- `s_address`  out  8  S RAM address.
- `s_data_in`  in  8  S RAM read data.
- `s_data_out`  out  8  S RAM write data.
- `s_write_enable`  out  1  S RAM write strobe.
- `rom_address`  out  $clog2(MSG_LEN)  encrypted ROM address (equals k).
- `rom_data`  in  8  encrypted byte.
- `ram_address`  out  $clog2(MSG_LEN)  decrypted RAM address (equals k).
- `ram_data_out`  out  8  plaintext byte.
- `ram_write_enable`  out  1  decrypted RAM write strobe.

## Operation
- Algorithm: i=0, j=0; for k=0..MSG_LEN-1: i=i+1; j=j+S[i]; swap S[i],S[j]; f=S[S[i]+S[j]]; out[k]=f^enc[k].
- All i/j/index sums are 8-bit and wrap modulo 256. k is a counter of width $clog2(MSG_LEN).
- Memory read model, for both RAM and ROM: the address is driven in cycle A and held in A+1. Read data is sampled at the end of A+1.
- Legal character: 8'h61–8'h7A ('a'–'z') or 8'h20 (space). The first illegal byte is still written. `valid` is then cleared and the run ends after that write.
- States and transitions:
  - IDLE: goes to INIT when `start`=1.
  - INIT: clears i, j, k; sets `valid` to 1.
  - INC_I: i<=i+1.
  - RD_SI: drives addr=i.
  - CAP_SI: drives addr=i; captures si; j<=j+s_data_in.
  - RD_SJ: drives addr=j.
  - CAP_SJ: drives addr=j; captures sj.
  - WR_SI: addr=i, data=sj, we=1.
  - WR_SJ: addr=j, data=si, we=1.
  - RD_F: drives addr=si+sj.
  - CAP_F: captures f from `s_data_in` and enc from `rom_data`.
  - WR_OUT: ram_we=1, data=f^enc, updates valid. Then goes to DONE if k==MSG_LEN-1 or the byte is illegal; otherwise k<=k+1 and goes to INC_I.
  - DONE: `finish`=1, then IDLE.
- When i==j, both swap writes store the same value. This is harmless and needs no special case.
- `rom_address` and `ram_address` are driven from k continuously.
- `start` outside IDLE is ignored.
- If `start` is still high in the IDLE cycle after DONE, a new run begins. The block does not restore S; the master must rerun the KSA first.
- Reset mid-run: the block enters IDLE on the next edge. No further writes occur, and S/RAM contents are left as-is.

## Timing
- Reset values: state IDLE; `finish`, `s_write_enable`, `ram_write_enable` = 0; `valid`=0. All addresses, write data, i, j and k are 0.
- Write strobes and addresses are decoded from the registered state only, so they are glitch-free and never asserted in IDLE, INIT or DONE.
- Cycle count, with start sampled at edge 0:
  - INIT occupies cycle 1.
  - Each byte takes 10 cycles.
  - A full run asserts `finish` in cycle 2+10·MSG_LEN, which is cycle 322 for MSG_LEN=32.
  - An abort on byte n asserts `finish` in cycle 2+10·(n+1).
- `valid` holds its value until the next INIT.

## Structure
- Shared package `rc4_pkg` holds:
  - the state enum;
  - the constants `CHAR_LO`=8'h61, `CHAR_HI`=8'h7A, `CHAR_SPACE`=8'h20;
  - the default `MSG_LEN`.
  The KSA stage and master import the same package.
- One combinational sub-module, `rc4_char_check` (8-bit in, legal out), is reused by the master's key-search logic.

## Test plan
- Identity S (S[x]=x), enc[0]=8'h63, enc[1]=8'h67, remainder from the golden model.
  - Required: RAM[0]=8'h61, RAM[1]=8'h62.
  - After byte 1: S[2]=3, S[3]=2.
  - `finish` in cycle 322 with `valid`=1.
- KSA-scheduled S for key 24'h000249, enc from the software RC4 model.
  - Required: all 32 RAM bytes and the final S match the model.
- Identity S, enc[0]=8'h02 (plaintext 8'h00).
  - Required: exactly one RAM write; `finish` in cycle 12 with `valid`=0.
- Reset asserted in cycle 50.
  - Required: all outputs 0 at the next edge and no writes afterwards.
  - After reloading S and restarting, results are identical to an uninterrupted run.
- `start` pulsed in cycle 100 of a run, then held high through `finish`.
  - Required: the pulse is ignored; a second run begins in the IDLE cycle after DONE.
- S with S[1]=8'hF0 and S[2]=8'h20.
  - Required: j wraps to 8'h10 at byte 1; the swap and f address follow modulo-256 arithmetic.
